// File: rtl/gd_multistart_sched.sv
// gd_multistart_sched: sweeps a 4D grid of start points, launches one GrDes run each, keeps the global best
// Ports: clk, rst_n (async, active-low); start pulse begins a sweep; busy/done/timeout_err status levels;
//   run_count = completed runs; best_z/best_a..d/best_init_a..d = global best result and its start point;
//   gd_start_op, gd_a..d_init drive GrDes; gd_done_op, gd_z_min, gd_a..d_min come back from GrDes.
module gd_multistart_sched #(
    parameter int GRID_MIN       = -4,
    parameter int GRID_MAX       = 4,
    parameter int GRID_STEP      = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [15:0]        run_count,
    output logic signed [31:0] best_z,
    output logic signed [7:0]  best_a,
    output logic signed [7:0]  best_b,
    output logic signed [7:0]  best_c,
    output logic signed [7:0]  best_d,
    output logic signed [7:0]  best_init_a,
    output logic signed [7:0]  best_init_b,
    output logic signed [7:0]  best_init_c,
    output logic signed [7:0]  best_init_d,
    output logic               gd_start_op,
    output logic signed [7:0]  gd_a_init,
    output logic signed [7:0]  gd_b_init,
    output logic signed [7:0]  gd_c_init,
    output logic signed [7:0]  gd_d_init,
    input  logic               gd_done_op,
    input  logic signed [31:0] gd_z_min,
    input  logic signed [7:0]  gd_a_min,
    input  logic signed [7:0]  gd_b_min,
    input  logic signed [7:0]  gd_c_min,
    input  logic signed [7:0]  gd_d_min
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + GAP_CYCLES + 1);
    localparam logic signed [9:0]  MAX10  = 10'(GRID_MAX);
    localparam logic signed [9:0]  STEP10 = 10'(GRID_STEP);
    localparam logic signed [7:0]  MIN8   = 8'(GRID_MIN);
    localparam logic signed [31:0] Z_INIT = 32'sh7FFF_FFFF;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, RELEASE, ADVANCE, FINISH} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic signed [7:0] pt [4];
    logic signed [7:0] pt_nx [4];
    logic signed [9:0] sum;
    logic              carry, tmo, gap_ok;

    assign {gd_a_init, gd_b_init, gd_c_init, gd_d_init} = {pt[0], pt[1], pt[2], pt[3]};
    assign tmo    = cnt == CW'(TIMEOUT_CYCLES);
    // cnt counts consecutive RELEASE cycles with gd_done_op low
    assign gap_ok = !gd_done_op && cnt >= CW'(GAP_CYCLES - 1);

    // Odometer: d fastest, a slowest; 10-bit sum so the overflow test never wraps
    always_comb begin
        carry = 1'b1;
        sum   = '0;
        for (int i = 3; i >= 0; i--) begin
            sum      = 10'(pt[i]) + STEP10;
            pt_nx[i] = !carry ? pt[i] : (sum > MAX10) ? MIN8 : sum[7:0];
            carry    = carry && (sum > MAX10);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LAUNCH : IDLE;
            LAUNCH:  state_nx = WAIT;
            WAIT:    state_nx = gd_done_op ? CAPTURE : tmo ? FINISH : WAIT;
            CAPTURE: state_nx = RELEASE;
            RELEASE: state_nx = gap_ok ? ADVANCE : RELEASE;
            ADVANCE: state_nx = carry ? FINISH : LAUNCH;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            run_count   <= '0;
            best_z      <= Z_INIT;
            {best_a, best_b, best_c, best_d} <= '0;
            {best_init_a, best_init_b, best_init_c, best_init_d} <= '0;
            gd_start_op <= 1'b0;
            pt          <= '{default: MIN8};
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    busy        <= 1'b1;
                    done        <= 1'b0;
                    timeout_err <= 1'b0;
                    run_count   <= '0;
                    best_z      <= Z_INIT;
                    pt          <= '{default: MIN8};
                end
                LAUNCH: begin
                    gd_start_op <= 1'b1;
                    cnt         <= '0;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // GrDes is stuck until its own reset, so the sweep is abandoned
                    if (!gd_done_op && tmo) begin
                        timeout_err <= 1'b1;
                        gd_start_op <= 1'b0;
                    end
                end
                CAPTURE: begin
                    run_count <= run_count + 16'(~&run_count);
                    cnt       <= '0;
                    // strict compare: ties keep the earlier run
                    if (gd_z_min < best_z) begin
                        best_z <= gd_z_min;
                        {best_a, best_b, best_c, best_d} <= {gd_a_min, gd_b_min, gd_c_min, gd_d_min};
                        {best_init_a, best_init_b, best_init_c, best_init_d} <= {pt[0], pt[1], pt[2], pt[3]};
                    end
                end
                RELEASE: begin
                    gd_start_op <= 1'b0;
                    cnt         <= gd_done_op ? '0 : cnt + 1'b1;
                end
                ADVANCE: pt <= pt_nx;
                FINISH: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    gd_start_op <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gd_multistart_sched.sv
// tb_gd_multistart_sched: three sequencers (default grid, single point, short timeout) driven by a GrDes model
module tb_gd_multistart_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic               start [3];
    logic               busy [3], done [3], terr [3], sop [3], gdone [3];
    logic [15:0]        rc [3];
    logic signed [31:0] bz [3], gz [3];
    logic signed [7:0]  bb [3][4], bi [3][4], gi [3][4], gm [3][4];

    int pmin [3] = '{-4, 3, -4};
    int pmax [3] = '{4, 3, 4};
    int pstep [3] = '{4, 4, 4};

    for (genvar k = 0; k < 3; k++) begin : g_dut
        gd_multistart_sched #(
            .GRID_MIN(k == 1 ? 3 : -4), .GRID_MAX(k == 1 ? 3 : 4), .GRID_STEP(4),
            .TIMEOUT_CYCLES(k == 2 ? 16 : 4096), .GAP_CYCLES(2)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[k]), .busy(busy[k]), .done(done[k]),
            .timeout_err(terr[k]), .run_count(rc[k]), .best_z(bz[k]),
            .best_a(bb[k][0]), .best_b(bb[k][1]), .best_c(bb[k][2]), .best_d(bb[k][3]),
            .best_init_a(bi[k][0]), .best_init_b(bi[k][1]), .best_init_c(bi[k][2]), .best_init_d(bi[k][3]),
            .gd_start_op(sop[k]),
            .gd_a_init(gi[k][0]), .gd_b_init(gi[k][1]), .gd_c_init(gi[k][2]), .gd_d_init(gi[k][3]),
            .gd_done_op(gdone[k]), .gd_z_min(gz[k]),
            .gd_a_min(gm[k][0]), .gd_b_min(gm[k][1]), .gd_c_min(gm[k][2]), .gd_d_min(gm[k][3])
        );
    end

    // GrDes model state and run log of instance 0
    int  lat [3], holdc [3], lc [3], hi [3], lowc [3];
    int  viol [3] = '{0, 0, 0};
    int  hold_cfg [3] = '{0, 0, 0};
    bit  never [3] = '{0, 0, 0};
    bit  psop [3], pbusy [3], infl [3];
    int  zmode = 0;
    int  s, v;
    logic signed [7:0] lp [3][4];
    int  rz [$];
    logic [31:0] rp [$], rm [$];

    // i-th start point of a sweep: mixed-radix digits of i, a most significant
    function automatic logic signed [7:0] exp_coord(int k, int idx, int axis);
        int n = (pmax[k] - pmin[k]) / pstep[k] + 1;
        int dv = n ** (3 - axis);
        return 8'(pmin[k] + ((idx / dv) % n) * pstep[k]);
    endfunction

    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (!rst_n) begin
                gdone[m] = 1'b0; gz[m] = '0; infl[m] = 0; psop[m] = 0; pbusy[m] = 0;
                lc[m] = 0; hi[m] = 0; lowc[m] = 100; holdc[m] = 0;
                for (int j = 0; j < 4; j++) gm[m][j] = '0;
            end else begin
                if (busy[m] && !pbusy[m]) begin
                    lc[m] = 0;
                    if (m == 0) begin rz.delete(); rp.delete(); rm.delete(); end
                end
                pbusy[m] = busy[m];
                lowc[m] = gdone[m] ? 0 : lowc[m] + 1;
                if (sop[m] && !psop[m]) begin
                    for (int j = 0; j < 4; j++) begin
                        if (gi[m][j] !== exp_coord(m, lc[m], j)) viol[m]++;
                        lp[m][j] = gi[m][j];
                    end
                    if (gdone[m] || lowc[m] < 2) viol[m]++;
                    lc[m]++; hi[m] = 0; infl[m] = 1; lat[m] = int'($urandom_range(1, 5));
                end
                if (sop[m]) begin
                    hi[m]++;
                    for (int j = 0; j < 4; j++) if (gi[m][j] !== lp[m][j]) viol[m]++;
                end
                if (infl[m] && !gdone[m] && !never[m]) begin
                    lat[m]--;
                    if (lat[m] == 0) begin
                        s = 0;
                        for (int j = 0; j < 4; j++) begin v = lp[m][j]; s += v * v; gm[m][j] = lp[m][j]; end
                        gz[m] = s * 256;
                        if (m == 0 && zmode == 1) gz[m] = 32'sh100;
                        if (m == 0 && zmode == 2) begin
                            gz[m] = (int'($urandom_range(0, 4)) - 2) * 256;
                            for (int j = 0; j < 4; j++) gm[m][j] = 8'($urandom);
                        end
                        gdone[m] = 1'b1; holdc[m] = hold_cfg[m];
                        if (m == 0) begin
                            rz.push_back(gz[0]);
                            rp.push_back({lp[0][0], lp[0][1], lp[0][2], lp[0][3]});
                            rm.push_back({gm[0][0], gm[0][1], gm[0][2], gm[0][3]});
                        end
                    end
                end else if (gdone[m] && !sop[m]) begin
                    if (holdc[m] == 0) begin gdone[m] = 1'b0; infl[m] = 0; end
                    else holdc[m]--;
                end
                psop[m] = sop[m];
            end
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(int k);
        @(negedge clk); start[k] = 1'b1;
        @(negedge clk); start[k] = 1'b0;
    endtask

    task automatic wait_done(int k, int limit, string tag);
        int c = 0;
        while (!done[k] && c < limit) begin @(negedge clk); c++; end
        chk({tag, "_finished"}, 32'(done[k]), 1);
    endtask

    task automatic sweep(int k, string tag);
        pulse(k);
        chk({tag, "_busy"}, 32'(busy[k]), 1);
        chk({tag, "_done_clr"}, 32'(done[k]), 0);
        wait_done(k, 5000, tag);
        chk({tag, "_idle"}, 32'(busy[k]), 0);
        chk({tag, "_viol"}, 32'(viol[k]), 0);
    endtask

    task automatic check_best(string tag);
        int b = 0;
        for (int i = 1; i < rz.size(); i++) if (rz[i] < rz[b]) b = i;
        chk({tag, "_runs"}, 32'(rc[0]), 32'(rz.size()));
        chk({tag, "_bz"}, bz[0], rz[b]);
        chk({tag, "_binit"}, {bi[0][0], bi[0][1], bi[0][2], bi[0][3]}, rp[b]);
        chk({tag, "_bmin"}, {bb[0][0], bb[0][1], bb[0][2], bb[0][3]}, rm[b]);
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_busy"}, 32'(busy[0]), 0);
        chk({tag, "_done"}, 32'(done[0]), 0);
        chk({tag, "_terr"}, 32'(terr[0]), 0);
        chk({tag, "_rc"}, 32'(rc[0]), 0);
        chk({tag, "_sop"}, 32'(sop[0]), 0);
        chk({tag, "_bz"}, bz[0], 32'h7FFF_FFFF);
        chk({tag, "_bmin"}, {bb[0][0], bb[0][1], bb[0][2], bb[0][3]}, 0);
        chk({tag, "_binit"}, {bi[0][0], bi[0][1], bi[0][2], bi[0][3]}, 0);
        chk({tag, "_init"}, {gi[0][0], gi[0][1], gi[0][2], gi[0][3]}, 32'hFCFC_FCFC);
    endtask

    initial begin
        int c;
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        chk("rst_init_u1", {gi[1][0], gi[1][1], gi[1][2], gi[1][3]}, 32'h0303_0303);
        rst_n = 1'b1;

        // quadratic bowl, with an ignored start pulse mid-sweep
        pulse(0);
        chk("bowl_busy", 32'(busy[0]), 1);
        c = 0;
        while (lc[0] < 10 && c < 2000) begin @(negedge clk); c++; end
        pulse(0);
        chk("bowl_ignored_start", 32'(done[0]), 0);
        wait_done(0, 5000, "bowl");
        chk("bowl_rc", 32'(rc[0]), 81);
        chk("bowl_launches", 32'(lc[0]), 81);
        chk("bowl_bz", bz[0], 0);
        chk("bowl_binit", {bi[0][0], bi[0][1], bi[0][2], bi[0][3]}, 0);
        chk("bowl_terr", 32'(terr[0]), 0);
        chk("bowl_viol", 32'(viol[0]), 0);
        check_best("bowl");

        // all runs tie: first run kept
        zmode = 1;
        sweep(0, "tie");
        chk("tie_binit", {bi[0][0], bi[0][1], bi[0][2], bi[0][3]}, 32'hFCFC_FCFC);
        chk("tie_bz", bz[0], 32'h100);
        check_best("tie");

        // random minima with frequent ties
        zmode = 2;
        for (int r = 0; r < 2; r++) begin
            sweep(0, "rand");
            check_best("rand");
        end

        // done_op held after start_op drops; model flags any early relaunch
        zmode = 0; hold_cfg[0] = 3;
        sweep(0, "hold");
        chk("hold_rc", 32'(rc[0]), 81);
        check_best("hold");
        hold_cfg[0] = 0;

        // single-point grid
        sweep(1, "single");
        chk("single_rc", 32'(rc[1]), 1);
        chk("single_launches", 32'(lc[1]), 1);
        chk("single_init", {gi[1][0], gi[1][1], gi[1][2], gi[1][3]}, 32'h0303_0303);
        chk("single_bz", bz[1], 32'h2400);
        chk("single_binit", {bi[1][0], bi[1][1], bi[1][2], bi[1][3]}, 32'h0303_0303);

        // GrDes never answers
        never[2] = 1'b1;
        sweep(2, "tmo");
        chk("tmo_terr", 32'(terr[2]), 1);
        chk("tmo_rc", 32'(rc[2]), 0);
        chk("tmo_hi", 32'(hi[2]), 17);
        chk("tmo_sop", 32'(sop[2]), 0);
        chk("tmo_bz", bz[2], 32'h7FFF_FFFF);
        pulse(2);
        chk("tmo_terr_clr", 32'(terr[2]), 0);
        wait_done(2, 200, "tmo2");

        // reset during run 5, then a full clean sweep
        pulse(0);
        c = 0;
        while (lc[0] < 5 && c < 2000) begin @(negedge clk); c++; end
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        sweep(0, "after_rst");
        chk("after_rst_rc", 32'(rc[0]), 81);
        chk("after_rst_launches", 32'(lc[0]), 81);
        check_best("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
